regfile_wb_queue: RTL and testbench

Write-back queue that sits in front of the 16-entry x 32-bit register bank and acts as its sole write initiator. It accepts write requests (register address + data) from the execute stage over a valid/ready handshake and buffers them in a small in-order FIFO. It drains them one per cycle into the register bank's write port, honouring a ready back-pressure signal. It also provides a two-port bypass lookup, so readers see data still pending in the queue.

---
 rtl/regfile_wb_queue.sv | 150 +++++++++++++++
 tb/tb_regfile_wb_queue.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//
// Write-back queue in front of the 16 x 32 register bank. This block is the
// only thing that writes the bank. The execute stage pushes {addr, data}
// requests over a valid/ready handshake. The requests are kept in a small
// in-order FIFO and drained one per cycle into the bank write port, which can
// apply back-pressure through wr_ready. Two bypass lookup ports let readers
// see data that is still pending in the queue.
//
// Ports:
//   clk                  rising-edge clock
//   rst_n                asynchronous active-low reset
//   in_valid/in_ready    upstream request handshake (in_ready = !full)
//   in_addr/in_data      request destination register and data
//   wr_en/wr_ready       bank write handshake (wr_en = !empty)
//   wr_addr/wr_data      head entry; zero when empty
//   rd_addr1/rd_addr2    bypass lookup addresses
//   byp_hit*/byp_data*   youngest pending match per port; data zero on miss
//   count                number of occupied entries
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_ready,
  input  logic [ADDR_W-1:0]          rd_addr1,
  input  logic [ADDR_W-1:0]          rd_addr2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [DATA_W-1:0]          byp_data1,
  output logic [DATA_W-1:0]          byp_data2,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Queue storage and bookkeeping
  logic [ADDR_W-1:0] addr_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0]  valid_r;
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;

  logic              full_s;
  logic              empty_s;
  logic              enq_s;
  logic              deq_s;

  // Status flags come only from registered state. This means wr_ready never
  // reaches in_ready combinationally. A full queue therefore refuses a request
  // even in a cycle where it is draining an entry.
  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign empty_s  = (count_r == {CNT_W{1'b0}});
  assign in_ready = ~full_s;
  assign wr_en    = ~empty_s;
  assign count    = count_r;

  assign enq_s = in_valid & ~full_s;
  assign deq_s = ~empty_s & wr_ready;

  // Queue state update: enqueue at tail, dequeue at head, occupancy count.
  // Enqueue and dequeue can never address the same slot in one cycle.
  // That would need the queue to be full (no enqueue) or empty (no dequeue).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_W{1'b0}};
        data_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (deq_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PTR_W'(1);
      end
      if (enq_s) begin
        addr_mem_r[tail_r] <= in_addr;
        data_mem_r[tail_r] <= in_data;
        valid_r[tail_r]    <= 1'b1;
        tail_r             <= tail_r + PTR_W'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry drives the bank write port. It is forced to zero when no valid
  // entry is present.
  always_comb begin
    wr_addr = {ADDR_W{1'b0}};
    wr_data = {DATA_W{1'b0}};
    if (valid_r[head_r]) begin
      wr_addr = addr_mem_r[head_r];
      wr_data = data_mem_r[head_r];
    end else begin
      wr_addr = {ADDR_W{1'b0}};
      wr_data = {DATA_W{1'b0}};
    end
  end

  // Bypass lookup. Entries are walked from oldest (head) to youngest, and each
  // later match overrides the earlier one. The youngest pending write to an
  // address therefore wins. The head entry is still visible in the cycle it
  // is being dequeued.
  always_comb begin : bypass_scan
    logic [PTR_W-1:0] idx_v;
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = {DATA_W{1'b0}};
    byp_data2 = {DATA_W{1'b0}};
    idx_v     = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx_v = head_r + PTR_W'(i);
      if (valid_r[idx_v] && (addr_mem_r[idx_v] == rd_addr1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = data_mem_r[idx_v];
      end else begin
        byp_hit1  = byp_hit1;
        byp_data1 = byp_data1;
      end
      if (valid_r[idx_v] && (addr_mem_r[idx_v] == rd_addr2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = data_mem_r[idx_v];
      end else begin
        byp_hit2  = byp_hit2;
        byp_data2 = byp_data2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } entry_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;
  logic [2:0]        count;

  int total;
  int bad;

  entry_t mq[$];    // reference model: pending writes, oldest first
  entry_t wlog[$];  // writes actually issued to the bank

  regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the queue is emptied on reset. On each edge it accepts a request
  // when not full (judged before the edge) and pops the head when the bank
  // accepts it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else if (in_valid && mq.size() < DEPTH) begin
      if (wr_ready && mq.size() > 0) void'(mq.pop_front());
      mq.push_back('{in_addr, in_data});
    end else if (wr_ready && mq.size() > 0) begin
      void'(mq.pop_front());
    end
  end

  // Record every write handed to the bank.
  always @(posedge clk) begin
    if (rst_n && wr_en && wr_ready) wlog.push_back('{wr_addr, wr_data});
  end

  // Compare the DUT outputs against the model once per cycle, on the falling edge.
  logic              e_hit1, e_hit2;
  logic [DATA_W-1:0] e_d1, e_d2;
  always @(negedge clk) begin
    e_hit1 = 1'b0; e_hit2 = 1'b0; e_d1 = '0; e_d2 = '0;
    foreach (mq[i]) begin
      if (mq[i].a == rd_addr1) begin e_hit1 = 1'b1; e_d1 = mq[i].d; end
      if (mq[i].a == rd_addr2) begin e_hit2 = 1'b1; e_d2 = mq[i].d; end
    end
    chk("m_in_ready", in_ready, mq.size() < DEPTH);
    chk("m_wr_en", wr_en, mq.size() > 0);
    chk("m_count", count, mq.size());
    chk("m_wr_addr", wr_addr, (mq.size() > 0) ? mq[0].a : 4'd0);
    chk("m_wr_data", wr_data, (mq.size() > 0) ? mq[0].d : 32'd0);
    chk("m_byp_hit1", byp_hit1, e_hit1);
    chk("m_byp_data1", byp_data1, e_d1);
    chk("m_byp_hit2", byp_hit2, e_hit2);
    chk("m_byp_data2", byp_data2, e_d2);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_log(input string name, input int idx,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (idx < wlog.size()) begin
      chk(name, {wlog[idx].a, wlog[idx].d}, {a, d});
    end else begin
      chk(name, 64'hFFFF_FFFF_FFFF_FFFF, {a, d});
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_addr = 4'd0; in_data = 32'd0;
    wr_ready = 1'b1; rd_addr1 = 4'd0; rd_addr2 = 4'd0;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_count", count, 3'd0);

    // Single write
    tick();
    in_valid = 1'b1; in_addr = 4'd3; in_data = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    chk("single_wr_en", wr_en, 1'b1);
    chk("single_wr_addr", wr_addr, 4'd3);
    chk("single_wr_data", wr_data, 32'hDEAD_BEEF);
    tick();
    chk("single_drained_count", count, 3'd0);
    chk("single_drained_wr_en", wr_en, 1'b0);

    // Fill and back-pressure
    wlog.delete();
    wr_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_addr = 4'(k); in_data = 32'(k);
      tick();
    end
    chk("fill_count", count, 3'd4);
    chk("fill_in_ready", in_ready, 1'b0);
    in_addr = 4'd5; in_data = 32'd5;
    tick();
    chk("fill_held_count", count, 3'd4);
    wr_ready = 1'b1;
    tick();
    chk("fill_ready_back", in_ready, 1'b1);
    chk("fill_after_deq_count", count, 3'd3);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("fill_log_size", wlog.size(), 5);
    for (int k = 0; k < 5; k++) chk_log("fill_order", k, 4'(k + 1), 32'(k + 1));

    // Wrap-around streaming
    wlog.delete();
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_addr = 4'(k + 6); in_data = 32'h100 + 32'(k);
      tick();
      chk("wrap_count_le1", count <= 3'd1, 1'b1);
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("wrap_log_size", wlog.size(), 10);
    for (int k = 0; k < 10; k++) chk_log("wrap_order", k, 4'(k + 6), 32'h100 + 32'(k));

    // Bypass youngest-wins
    wr_ready = 1'b0;
    in_valid = 1'b1; in_addr = 4'd5; in_data = 32'hA; tick();
    in_addr = 4'd7; in_data = 32'hB; tick();
    in_addr = 4'd5; in_data = 32'hC; tick();
    in_valid = 1'b0;
    rd_addr1 = 4'd5; rd_addr2 = 4'd7;
    #1;
    chk("byp1_hit", byp_hit1, 1'b1);
    chk("byp1_data_young", byp_data1, 32'hC);
    chk("byp2_hit", byp_hit2, 1'b1);
    chk("byp2_data", byp_data2, 32'hB);
    rd_addr1 = 4'd9;
    #1;
    chk("byp1_miss_hit", byp_hit1, 1'b0);
    chk("byp1_miss_data", byp_data1, 32'd0);
    rd_addr2 = 4'd5;
    #1;
    chk("byp2_same_entry", byp_data2, 32'hC);
    wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("byp_drained", count, 3'd0);

    // Simultaneous enqueue and dequeue at count 2
    wlog.delete();
    wr_ready = 1'b0;
    in_valid = 1'b1; in_addr = 4'd1; in_data = 32'h300; tick();
    in_addr = 4'd2; in_data = 32'h301; tick();
    chk("sim_pre_count", count, 3'd2);
    wr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_addr = 4'(k + 10); in_data = 32'h200 + 32'(k);
      tick();
      chk("sim_count_steady", count, 3'd2);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("sim_log_size", wlog.size(), 8);
    chk_log("sim_order", 0, 4'd1, 32'h300);
    chk_log("sim_order", 1, 4'd2, 32'h301);
    for (int k = 0; k < 6; k++) chk_log("sim_order", k + 2, 4'(k + 10), 32'h200 + 32'(k));

    // Reset mid-operation
    wr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_addr = 4'(k + 1); in_data = 32'h400 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    chk("mid_pre_count", count, 3'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_count", count, 3'd0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    wlog.delete();
    tick();
    rst_n = 1'b1; wr_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("mid_no_stale_writes", wlog.size(), 0);
    chk("mid_final_count", count, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
